saber_cmd_decoder: RTL and testbench

Command-side responder for the Saber compute core. It accepts the 35-bit host command stream, made of instruction writes (`command_we0`) and length writes (`command_we1`). It latches the operand fields, fires a one-cycle start pulse to exactly one functional unit (SHAKE, vector multiplier, copy, sampler, …), tracks the operation to completion and presents per-unit `done` levels. Those levels hold until the host clears them with opcode 0. It sits between the external command port and the functional units inside the compute core.

---
 rtl/saber_cmd_decoder.sv | 178 +++++++++++++++++
 tb/tb_saber_cmd_decoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saber_cmd_decoder.sv
// Command decoder for the Saber compute core: latches host operands and lengths,
// starts one functional unit per command and holds per-unit done levels until cleared.
module saber_cmd_decoder #(
  parameter int NUNITS = 11,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [34:0]       command_in,
  input  logic              command_we0,
  input  logic              command_we1,
  input  logic [NUNITS-1:0] unit_done,
  output logic [NUNITS-1:0] unit_start,
  output logic              unit_clr,
  output logic [AW-1:0]     dst_addr,
  output logic [AW-1:0]     src1_addr,
  output logic [AW-1:0]     src2_addr,
  output logic              shake_mode,
  output logic [15:0]       in_len,
  output logic [15:0]       out_len,
  output logic [NUNITS-1:0] done,
  output logic              busy,
  output logic              err_illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NUNITS-1:0] active_q, active_d;
  logic [NUNITS-1:0] start_q, start_d;
  logic [NUNITS-1:0] done_q, done_d;
  logic              clr_q, clr_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [AW-1:0]     src1_q, src1_d;
  logic [AW-1:0]     src2_q, src2_d;
  logic              mode_q, mode_d;
  logic [15:0]       in_len_q, in_len_d;
  logic [15:0]       out_len_q, out_len_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [4:0]        op;
  logic              op_zero;
  logic              op_legal;
  logic [NUNITS-1:0] op_onehot;

  assign op      = command_in[4:0];
  assign op_zero = (op == 5'd0);

  always_comb begin
    op_onehot = '0;
    op_legal  = 1'b1;
    case (op)
      5'd1, 5'd3: op_onehot[0]  = 1'b1;
      5'd6:       op_onehot[1]  = 1'b1;
      5'd7:       op_onehot[2]  = 1'b1;
      5'd8:       op_onehot[3]  = 1'b1;
      5'd9:       op_onehot[4]  = 1'b1;
      5'd10:      op_onehot[5]  = 1'b1;
      5'd12:      op_onehot[6]  = 1'b1;
      5'd13:      op_onehot[7]  = 1'b1;
      5'd14:      op_onehot[8]  = 1'b1;
      5'd15:      op_onehot[9]  = 1'b1;
      5'd16:      op_onehot[10] = 1'b1;
      default:    op_legal      = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    start_d   = '0;
    clr_d     = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    dst_d     = dst_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    mode_d    = mode_q;
    in_len_d  = in_len_q;
    out_len_d = out_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (command_we0 && !op_zero) begin
          if (op_legal) begin
            dst_d    = command_in[25 +: AW];
            src2_d   = command_in[15 +: AW];
            src1_d   = command_in[5 +: AW];
            mode_d   = (op == 5'd3);
            start_d  = op_onehot;
            active_d = op_onehot;
            state_d  = S_BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        // An abort in the same cycle as the unit's completion takes priority.
        if (command_we0 && op_zero) begin
          clr_d    = 1'b1;
          active_d = '0;
          state_d  = S_IDLE;
        end else if (|(unit_done & active_q)) begin
          done_d  = done_q | active_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (command_we0 && op_zero) begin
          done_d   = '0;
          err_d    = 1'b0;
          active_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (command_we1 && (state_q != S_BUSY)) begin
      in_len_d  = command_in[15:0];
      out_len_d = command_in[31:16];
    end

    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      active_q  <= '0;
      start_q   <= '0;
      clr_q     <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      dst_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      mode_q    <= 1'b0;
      in_len_q  <= '0;
      out_len_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      start_q   <= start_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dst_q     <= dst_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      mode_q    <= mode_d;
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      busy_q    <= busy_d;
    end
  end

  assign unit_start  = start_q;
  assign unit_clr    = clr_q;
  assign dst_addr    = dst_q;
  assign src1_addr   = src1_q;
  assign src2_addr   = src2_q;
  assign shake_mode  = mode_q;
  assign in_len      = in_len_q;
  assign out_len     = out_len_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_saber_cmd_decoder.sv
// Self-checking bench for saber_cmd_decoder: directed scenarios plus a random
// command stream compared against a behavioural model of the command protocol.
module tb_saber_cmd_decoder;
  localparam int NU = 11;
  localparam int AW = 10;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [34:0]   command_in = '0;
  logic          command_we0 = 1'b0;
  logic          command_we1 = 1'b0;
  logic [NU-1:0] unit_done = '0;
  logic [NU-1:0] unit_start;
  logic          unit_clr;
  logic [AW-1:0] dst_addr, src1_addr, src2_addr;
  logic          shake_mode;
  logic [15:0]   in_len, out_len;
  logic [NU-1:0] done;
  logic          busy;
  logic          err_illegal;

  int checks = 0;
  int errors = 0;
  int unit_of[32];
  int legal_ops[12] = '{1, 3, 6, 7, 8, 9, 10, 12, 13, 14, 15, 16};

  saber_cmd_decoder #(.NUNITS(NU), .AW(AW)) dut (
    .clk(clk), .rst(rst), .command_in(command_in), .command_we0(command_we0),
    .command_we1(command_we1), .unit_done(unit_done), .unit_start(unit_start),
    .unit_clr(unit_clr), .dst_addr(dst_addr), .src1_addr(src1_addr),
    .src2_addr(src2_addr), .shake_mode(shake_mode), .in_len(in_len),
    .out_len(out_len), .done(done), .busy(busy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mk(input int dst, input int s2, input int s1, input int op);
    return {dst[9:0], s2[9:0], s1[9:0], op[4:0]};
  endfunction

  function automatic logic [NU-1:0] oh(input int k);
    logic [NU-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic cyc(input logic w0, input logic w1, input logic [34:0] c, input logic [NU-1:0] ud);
    command_we0 = w0;
    command_we1 = w1;
    command_in  = c;
    unit_done   = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, '0, '0);
    checks++;
    if ({unit_start, unit_clr, dst_addr, src1_addr, src2_addr, shake_mode, in_len, out_len,
         done, busy, err_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%h clr=%b done=%h busy=%b err=%b, expected all zero",
               unit_start, unit_clr, done, busy, err_illegal);
    end
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_length_write();
    cyc(1'b0, 1'b1, {3'd0, 16'd3744, 16'd32}, '0);
    checks++;
    if (in_len !== 16'd32 || out_len !== 16'd3744) begin
      errors++;
      $display("FAIL len_write: got in=%0d out=%0d expected in=32 out=3744", in_len, out_len);
    end
    cyc(1'b1, 1'b0, mk(100, 0, 896, 3), '0);
    checks++;
    if (unit_start !== oh(0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL shake_start: got start=%h busy=%b expected start=%h busy=1", unit_start, busy, oh(0));
    end
    checks++;
    if (shake_mode !== 1'b1 || dst_addr !== 10'd100 || src1_addr !== 10'd896 || src2_addr !== 10'd0) begin
      errors++;
      $display("FAIL shake_operands: got mode=%b dst=%0d s1=%0d s2=%0d expected 1/100/896/0",
               shake_mode, dst_addr, src1_addr, src2_addr);
    end
    cyc(1'b0, 1'b0, '0, '0);
    checks++;
    if (unit_start !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_single: got start=%h busy=%b expected start=0 busy=1", unit_start, busy);
    end
    cyc(1'b0, 1'b0, '0, oh(0));
    checks++;
    if (done !== oh(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL shake_done: got done=%h busy=%b expected done=%h busy=0", done, busy, oh(0));
    end
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
    checks++;
    if (done !== '0 || in_len !== 16'd32) begin
      errors++;
      $display("FAIL shake_clear: got done=%h in_len=%0d expected done=0 in_len=32", done, in_len);
    end
  endtask

  task automatic test_held_strobe();
    int pulses;
    logic [34:0] c;
    pulses = 0;
    c = mk(164, 900, 256, 6);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b0, c, (i == 150) ? oh(1) : '0);
      if (unit_start[1] === 1'b1) pulses++;
      if (i == 149) begin
        checks++;
        if (done !== '0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL held_before_done: got done=%h busy=%b expected done=0 busy=1", done, busy);
        end
      end
      if (i == 150) begin
        checks++;
        if (done !== oh(1) || busy !== 1'b0) begin
          errors++;
          $display("FAIL held_done: got done=%h busy=%b expected done=%h busy=0", done, busy, oh(1));
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_pulses: got %0d start pulses expected 1", pulses);
    end
    checks++;
    if (dst_addr !== 10'd164 || src2_addr !== 10'd900 || src1_addr !== 10'd256 || shake_mode !== 1'b0) begin
      errors++;
      $display("FAIL held_operands: got dst=%0d s2=%0d s1=%0d mode=%b expected 164/900/256/0",
               dst_addr, src2_addr, src1_addr, shake_mode);
    end
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
    checks++;
    if (done !== '0 || busy !== 1'b0 || unit_start !== '0) begin
      errors++;
      $display("FAIL held_clear: got done=%h busy=%b start=%h expected all 0", done, busy, unit_start);
    end
  endtask

  task automatic test_abort();
    cyc(1'b1, 1'b0, mk(568, 52, 152, 12), '0);
    checks++;
    if (unit_start !== oh(6)) begin
      errors++;
      $display("FAIL copy_start: got %h expected %h", unit_start, oh(6));
    end
    cyc(1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
    checks++;
    if (unit_clr !== 1'b1 || busy !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL abort_clr: got clr=%b busy=%b done=%h expected clr=1 busy=0 done=0", unit_clr, busy, done);
    end
    cyc(1'b0, 1'b0, '0, oh(6));
    checks++;
    if (unit_clr !== 1'b0 || done !== '0 || busy !== 1'b0 || dst_addr !== 10'd568) begin
      errors++;
      $display("FAIL abort_late_done: got clr=%b done=%h busy=%b dst=%0d expected 0/0/0/568",
               unit_clr, done, busy, dst_addr);
    end
  endtask

  task automatic test_illegal();
    int bad_ops[2] = '{5, 2};
    foreach (bad_ops[j]) begin
      cyc(1'b1, 1'b0, mk(1, 2, 3, bad_ops[j]), '0);
      checks++;
      if (err_illegal !== 1'b1 || unit_start !== '0 || busy !== 1'b0 || dst_addr !== 10'd568) begin
        errors++;
        $display("FAIL illegal_op%0d: got err=%b start=%h busy=%b dst=%0d expected 1/0/0/568",
                 bad_ops[j], err_illegal, unit_start, busy, dst_addr);
      end
      cyc(1'b1, 1'b0, mk(7, 7, 7, 6), '0);
      checks++;
      if (unit_start !== '0 || err_illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_hold_op%0d: got start=%h err=%b expected start=0 err=1",
                 bad_ops[j], unit_start, err_illegal);
      end
      cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
      checks++;
      if (err_illegal !== 1'b0) begin
        errors++;
        $display("FAIL illegal_clear_op%0d: got err=%b expected 0", bad_ops[j], err_illegal);
      end
    end
  endtask

  task automatic test_boundary();
    logic [34:0] c;
    cyc(1'b1, 1'b0, mk(10, 20, 30, 13), '0);
    cyc(1'b0, 1'b0, '0, oh(7) | oh(1));
    checks++;
    if (done !== oh(7)) begin
      errors++;
      $display("FAIL sampler_only: got done=%h expected %h", done, oh(7));
    end
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
    cyc(1'b1, 1'b0, mk(11, 12, 13, 6), '0);
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), oh(1));
    checks++;
    if (done !== '0 || unit_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_done: got done=%h clr=%b busy=%b expected 0/1/0", done, unit_clr, busy);
    end
    c = mk($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 7);
    cyc(1'b1, 1'b1, c, '0);
    checks++;
    if (unit_start !== oh(2) || in_len !== c[15:0] || out_len !== c[31:16]) begin
      errors++;
      $display("FAIL we0_we1_same: got start=%h in=%h out=%h expected %h/%h/%h",
               unit_start, in_len, out_len, oh(2), c[15:0], c[31:16]);
    end
    cyc(1'b0, 1'b1, {3'd7, 16'hBEEF, 16'hCAFE}, '0);
    checks++;
    if (in_len !== c[15:0] || out_len !== c[31:16]) begin
      errors++;
      $display("FAIL len_frozen_busy: got in=%h out=%h expected %h/%h", in_len, out_len, c[15:0], c[31:16]);
    end
    cyc(1'b0, 1'b0, '0, oh(2));
    cyc(1'b0, 1'b1, {3'd7, 16'h1234, 16'h5678}, '0);
    checks++;
    if (done !== oh(2) || in_len !== 16'h5678 || out_len !== 16'h1234) begin
      errors++;
      $display("FAIL len_in_done: got done=%h in=%h out=%h expected %h/5678/1234", done, in_len, out_len, oh(2));
    end
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, mk(33, 44, 55, 15), '0);
    cyc(1'b0, 1'b0, '0, '0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({unit_start, unit_clr, dst_addr, src1_addr, src2_addr, shake_mode, in_len, out_len,
         done, busy, err_illegal} !== '0) begin
      errors++;
      $display("FAIL async_reset: got start=%h busy=%b dst=%0d in=%0d expected all zero",
               unit_start, busy, dst_addr, in_len);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, mk(1, 2, 3, 1), '0);
    checks++;
    if (unit_start !== oh(0) || busy !== 1'b1 || shake_mode !== 1'b0 || unit_clr !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_start: got start=%h busy=%b mode=%b clr=%b expected %h/1/0/0",
               unit_start, busy, shake_mode, unit_clr, oh(0));
    end
    cyc(1'b0, 1'b0, '0, oh(0));
    cyc(1'b1, 1'b0, mk(0, 0, 0, 0), '0);
  endtask

  task automatic test_random();
    int phase, unit, op, r;
    logic w0, w1;
    logic [34:0] c;
    logic [NU-1:0] ud;
    logic [NU-1:0] e_start, e_done;
    logic e_clr, e_err, e_mode, e_busy;
    logic [AW-1:0] e_dst, e_s1, e_s2;
    logic [15:0] e_in, e_out;
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    phase = P_IDLE; unit = 0;
    e_done = '0; e_err = 1'b0; e_mode = 1'b0; e_dst = '0; e_s1 = '0; e_s2 = '0; e_in = '0; e_out = '0;
    for (int i = 0; i < 2000 && errors < 20; i++) begin
      w0 = ($urandom_range(0, 2) == 0);
      w1 = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      op = (r < 3) ? 0 : (r < 8) ? legal_ops[$urandom_range(0, 11)] : $urandom_range(0, 31);
      c = {$urandom(), 3'b000};
      c[4:0] = op[4:0];
      ud = '0;
      if ($urandom_range(0, 3) == 0) ud = $urandom_range(0, 2047);
      if ($urandom_range(0, 5) == 0) ud[unit] = 1'b1;

      e_start = '0;
      e_clr = 1'b0;
      if (w1 && phase != P_RUN) begin
        e_in = c[15:0];
        e_out = c[31:16];
      end
      if (phase == P_IDLE) begin
        if (w0 && op != 0) begin
          if (unit_of[op] >= 0) begin
            unit = unit_of[op];
            e_start[unit] = 1'b1;
            e_dst = c[34:25]; e_s2 = c[24:15]; e_s1 = c[14:5];
            e_mode = (op == 3);
            phase = P_RUN;
          end else begin
            e_err = 1'b1;
            phase = P_FIN;
          end
        end
      end else if (phase == P_RUN) begin
        if (w0 && op == 0) begin
          e_clr = 1'b1;
          phase = P_IDLE;
        end else if (ud[unit]) begin
          e_done[unit] = 1'b1;
          phase = P_FIN;
        end
      end else if (w0 && op == 0) begin
        e_done = '0;
        e_err = 1'b0;
        phase = P_IDLE;
      end
      e_busy = (phase == P_RUN);

      cyc(w0, w1, c, ud);
      checks++;
      if ({unit_start, unit_clr, dst_addr, src1_addr, src2_addr, shake_mode, in_len, out_len,
           done, busy, err_illegal} !==
          {e_start, e_clr, e_dst, e_s1, e_s2, e_mode, e_in, e_out, e_done, e_busy, e_err}) begin
        errors++;
        $display("FAIL random_cycle%0d: got start=%h clr=%b dst=%h s1=%h s2=%h mode=%b in=%h out=%h done=%h busy=%b err=%b expected %h %b %h %h %h %b %h %h %h %b %b",
                 i, unit_start, unit_clr, dst_addr, src1_addr, src2_addr, shake_mode, in_len, out_len,
                 done, busy, err_illegal, e_start, e_clr, e_dst, e_s1, e_s2, e_mode, e_in, e_out,
                 e_done, e_busy, e_err);
      end
    end
  endtask

  initial begin
    foreach (unit_of[k]) unit_of[k] = -1;
    foreach (legal_ops[k]) unit_of[legal_ops[k]] = (k == 0) ? 0 : k - 1;
    test_reset();
    test_length_write();
    test_held_strobe();
    test_abort();
    test_illegal();
    test_boundary();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
